// File: rtl/acc_pkg.sv
// Shared constants for the multi-channel accumulator selector.
// Operation codes carried on 'sel' plus signed range helpers.
package acc_pkg;

    localparam logic [1:0] SEL_CLR  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_ACC  = 2'd2;
    localparam logic [1:0] SEL_READ = 2'd3;

    // Largest positive two's-complement value of width n, zero-extended to 64 bits
    function automatic logic [63:0] smax(input int unsigned n);
        return (64'(1) << (n - 1)) - 64'(1);
    endfunction

    // Most negative two's-complement value of width n; caller truncates to n bits
    function automatic logic [63:0] smin(input int unsigned n);
        return ~smax(n);
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed adder with overflow detect.
// Build option ACC_SAT_EN: clamp on overflow; otherwise wrap modulo 2^N.
module sat_add
    import acc_pkg::*;
#(
    parameter int unsigned N = 25
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         ovf
);

    logic [N:0] full;

    // Sign-extend both operands so the N+1 bit result never loses the true sign
    always_comb begin
        full = {a[N-1], a} + {b[N-1], b};
        ovf  = full[N] ^ full[N-1];
    end

`ifdef ACC_SAT_EN
    localparam logic [N-1:0] MAXV = N'(smax(N));
    localparam logic [N-1:0] MINV = N'(smin(N));

    // Clamp toward the true sign of the sum on overflow
    always_comb begin
        sum = full[N-1:0];
        if (ovf) begin
            sum = full[N] ? MINV : MAXV;
        end
    end
`else
    // Plain wrap: low N bits of the extended sum
    always_comb begin
        sum = full[N-1:0];
    end
`endif

endmodule

// File: rtl/mux_ac_multicanal.sv
// Multi-channel registered accumulator selector.
// CH signed N-bit accumulators; one CLR/LOAD/ACC/READ per accepted request,
// result registered one cycle later behind a valid/ready output stage.
// Build option ACC_SAT_EN selects saturating accumulation (see sat_add).
module mux_ac_multicanal
    import acc_pkg::*;
#(
    parameter  int unsigned N   = 25,
    parameter  int unsigned CH  = 4,
    localparam int unsigned CHW = $clog2(CH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CHW-1:0] in_ch,
    input  logic [1:0]     sel,
    input  logic [N-1:0]   uk,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CHW-1:0] out_ch,
    output logic [N-1:0]   out,
    output logic           ovf
);

    logic [N-1:0] acc [CH];
    logic         ch_ok;
    logic [N-1:0] cur;
    logic [N-1:0] add_sum;
    logic         add_ovf;
    logic [N-1:0] res;
    logic         res_ovf;
    logic         wr;
    logic         accept;

    // Single output register: a new request fits whenever the slot drains this cycle
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Current value of the addressed channel; out-of-range channels read as zero
    always_comb begin
        ch_ok = 32'(in_ch) < CH;
        cur   = ch_ok ? acc[in_ch] : '0;
    end

    sat_add #(.N(N)) u_add (
        .a   (cur),
        .b   (uk),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Operation decode: result value, overflow flag and whether the bank is written
    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        wr      = 1'b0;
        if (ch_ok) begin
            case (sel)
                SEL_CLR: begin
                    res = '0;
                    wr  = 1'b1;
                end
                SEL_LOAD: begin
                    res = uk;
                    wr  = 1'b1;
                end
                SEL_ACC: begin
                    res     = add_sum;
                    res_ovf = add_ovf;
                    wr      = 1'b1;
                end
                default: begin
                    res = cur;
                end
            endcase
        end
    end

    // Accumulator bank update on accepted writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CH); i++) begin
                acc[i] <= '0;
            end
        end else if (accept && wr) begin
            acc[in_ch] <= res;
        end
    end

    // Output register and valid handshake; payload holds once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_ch    <= '0;
            ovf       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out       <= res;
            out_ch    <= in_ch;
            ovf       <= res_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_ac_multicanal.sv
// Self-checking bench for mux_ac_multicanal (N=25, CH=4).
// Honours ACC_SAT_EN in its reference model the same way the design does.
module tb_mux_ac_multicanal;

    localparam int NW = 25;
    localparam longint MAXV = (longint'(1) << (NW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (NW - 1));
    localparam longint MODV = longint'(1) << NW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_ch;
    logic [1:0]    sel;
    logic [NW-1:0] uk;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_ch;
    logic [NW-1:0] dout;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    longint macc [4];

    mux_ac_multicanal #(.N(NW), .CH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .sel       (sel),
        .uk        (uk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out       (dout),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: apply one operation to the channel array using integer arithmetic
    function automatic void model_op(input int ch, input int s, input longint u,
                                     output longint r, output bit o);
        longint t;
        o = 1'b0;
        r = 0;
        case (s)
            0: begin macc[ch] = 0; r = 0; end
            1: begin macc[ch] = u; r = u; end
            2: begin
                t = macc[ch] + u;
                if (t > MAXV || t < MINV) begin
                    o = 1'b1;
`ifdef ACC_SAT_EN
                    t = (t > MAXV) ? MAXV : MINV;
`else
                    t = (t > MAXV) ? t - MODV : t + MODV;
`endif
                end
                macc[ch] = t;
                r = t;
            end
            default: r = macc[ch];
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) macc[i] = 0;
    endfunction

    // Issue one request (left asserted for back-to-back use) and check its result
    task automatic op(input int ch, input int s, input longint u, input string name);
        longint r;
        bit o;
        in_valid = 1'b1;
        in_ch = 2'(ch);
        sel = 2'(s);
        uk = NW'(u);
        @(posedge clk); #1;
        model_op(ch, s, u, r, o);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid: got %b exp 1", name, out_valid); end
        checks++;
        if (dout !== NW'(r)) begin errors++; $display("FAIL %s out: got %0d exp %0d", name, $signed(dout), r); end
        checks++;
        if (out_ch !== 2'(ch)) begin errors++; $display("FAIL %s out_ch: got %0d exp %0d", name, out_ch, ch); end
        checks++;
        if (ovf !== o) begin errors++; $display("FAIL %s ovf: got %b exp %b", name, ovf, o); end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_ch = '0;
        sel = '0;
        uk = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b exp 0", out_valid); end
        checks++;
        if (dout !== '0) begin errors++; $display("FAIL reset out: got %0d exp 0", dout); end
        checks++;
        if (out_ch !== '0 || ovf !== 1'b0) begin errors++; $display("FAIL reset ch/ovf: got %0d/%b exp 0/0", out_ch, ovf); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b exp 1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_all();
        for (int c = 0; c < 4; c++) op(c, 3, 0, "read_init");
        idle();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL read_drain out_valid: got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        op(1, 1, 100, "b2b_load");
        op(1, 2, -30, "b2b_acc");
        op(1, 3, 0, "b2b_read");
        idle();
    endtask

    task automatic test_overflow();
        op(2, 1, MAXV, "ovf_pos_load");
        op(2, 2, 1, "ovf_pos_acc");
        op(2, 1, MINV, "ovf_neg_load");
        op(2, 2, -1, "ovf_neg_acc");
        op(2, 1, MAXV - 1, "ovf_edge_load");
        op(2, 2, 1, "ovf_edge_acc");
        op(2, 3, 0, "ovf_read");
        idle();
    endtask

    task automatic test_backpressure();
        longint r;
        bit o;
        out_ready = 1'b0;
        op(0, 1, 7, "bp_first");
        in_ch = 2'd0;
        sel = 2'd2;
        uk = NW'(3);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready: got %b exp 0 cyc %0d", in_ready, k); end
            checks++;
            if (out_valid !== 1'b1 || dout !== NW'(7)) begin
                errors++; $display("FAIL bp hold: got v=%b out=%0d exp v=1 out=7 cyc %0d", out_valid, dout, k);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp release in_ready: got %b exp 1", in_ready); end
        @(posedge clk); #1;
        model_op(0, 2, 3, r, o);
        checks++;
        if (out_valid !== 1'b1 || dout !== NW'(r)) begin
            errors++; $display("FAIL bp second: got v=%b out=%0d exp v=1 out=%0d", out_valid, dout, r);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp single result: got %b exp 0", out_valid); end
    endtask

    task automatic test_isolation();
        op(0, 1, 5, "iso_load0");
        op(3, 1, 9, "iso_load3");
        op(0, 0, 0, "iso_clr0");
        op(3, 3, 0, "iso_read3");
        op(0, 3, 0, "iso_read0");
        idle();
    endtask

    task automatic test_random();
        bit exp_valid = 1'b0;
        longint exp_out = 0;
        int exp_ch = 0;
        bit exp_ovf = 1'b0;
        logic [NW-1:0] raw;
        for (int it = 0; it < 400; it++) begin
            bit iv, orr, acc_now;
            int ch, s, pick;
            longint u, r;
            bit o;
            iv = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 3) != 0);
            ch = $urandom_range(0, 3);
            s = $urandom_range(0, 3);
            pick = $urandom_range(0, 7);
            raw = NW'($urandom);
            u = (pick == 0) ? MAXV : (pick == 1) ? MINV : longint'($signed(raw));
            in_valid = iv;
            out_ready = orr;
            in_ch = 2'(ch);
            sel = 2'(s);
            uk = NW'(u);
            #1;
            acc_now = iv && (!exp_valid || orr);
            checks++;
            if (in_ready !== (!exp_valid || orr)) begin
                errors++; $display("FAIL rnd in_ready it %0d: got %b exp %b", it, in_ready, !exp_valid || orr);
            end
            @(posedge clk); #1;
            if (acc_now) begin
                model_op(ch, s, u, r, o);
                exp_valid = 1'b1;
                exp_out = r;
                exp_ch = ch;
                exp_ovf = o;
            end else if (orr) begin
                exp_valid = 1'b0;
            end
            checks++;
            if (out_valid !== exp_valid) begin errors++; $display("FAIL rnd out_valid it %0d: got %b exp %b", it, out_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (dout !== NW'(exp_out) || out_ch !== 2'(exp_ch) || ovf !== exp_ovf) begin
                    errors++;
                    $display("FAIL rnd payload it %0d: got out=%0d ch=%0d ovf=%b exp out=%0d ch=%0d ovf=%b",
                             it, $signed(dout), out_ch, ovf, exp_out, exp_ch, exp_ovf);
                end
            end
        end
        out_ready = 1'b1;
        idle();
        idle();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        op(2, 1, 100, "rst_load");
        op(2, 2, -30, "rst_acc");
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid: got %b exp 0", out_valid); end
        checks++;
        if (dout !== '0 || ovf !== 1'b0) begin errors++; $display("FAIL rst_mid out: got %0d/%b exp 0/0", dout, ovf); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op(2, 3, 0, "rst_read2");
        op(1, 3, 0, "rst_read1");
        idle();
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_isolation();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
